// File: rtl/gpio_pkg.sv
// Shared definitions for the memory-mapped GPIO input port: register
// offsets within the 16-byte window and the event counter width.
package gpio_pkg;

  // Word offset (addr[3:2]) of each register in the window
  typedef enum logic [1:0] {
    GPIO_STATE = 2'd0,
    GPIO_RISE  = 2'd1,
    GPIO_COUNT = 2'd2,
    GPIO_MASK  = 2'd3
  } gpio_off_e;

  localparam int COUNT_W = 16;

endpackage

// File: rtl/debounce_bit.sv
// One input pin: two-flop synchroniser followed by a stability counter.
// The accepted level (stb) only follows the synchronised pin once it has
// differed from stb for DB_CYCLES consecutive clocks. The next-state of stb
// is exported so the parent can detect edges on the update edge itself.
module debounce_bit #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pin,
  output logic o_stb,
  output logic o_stb_next
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic          r_s1, r_s2, r_stb;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          w_stb_next;

  // Count clocks of disagreement; accept the new level on the last one
  always_comb begin
    w_stb_next = r_stb;
    w_cnt_next = r_cnt;
    if (r_s2 == r_stb) begin
      w_cnt_next = '0;
    end else if (r_cnt == LAST) begin
      w_stb_next = r_s2;
      w_cnt_next = '0;
    end else begin
      w_cnt_next = r_cnt + 1'b1;
    end
  end

  // Synchroniser and debounce state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_stb <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1  <= i_pin;
      r_s2  <= r_s1;
      r_stb <= w_stb_next;
      r_cnt <= w_cnt_next;
    end
  end

  assign o_stb      = r_stb;
  assign o_stb_next = w_stb_next;

endmodule

// File: rtl/gpio_input_port.sv
// Memory-mapped board-input peripheral on the core data bus. Debounced pin
// levels, sticky rising-edge flags (W1C), a 16-bit event counter, an
// interrupt mask and a registered masked interrupt. Reads are combinational
// and return 0 outside the window so the bus can simply OR sources.
module gpio_input_port
  import gpio_pkg::*;
#(
  parameter int          WIDTH     = 8,
  parameter int          DB_CYCLES = 16,
  parameter logic [31:0] BASE      = 32'hFFFF_FF00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pins_in,
  input  logic [31:0]      addr,
  input  logic             mem_write,
  input  logic [31:0]      write_data,
  output logic [31:0]      read_data,
  output logic             irq
);

  logic [WIDTH-1:0]   w_stb, w_stb_next, w_rise_ev;
  logic [WIDTH-1:0]   r_rise, r_mask;
  logic [COUNT_W-1:0] r_count;
  logic               r_irq;

  logic [WIDTH-1:0]   w_rise_next, w_mask_next, w_clr;
  logic [COUNT_W-1:0] w_count_next;
  logic               w_sel, w_wr;
  gpio_off_e          w_off;
  logic               w_unused;

  // Per-pin synchroniser + debounce
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pin
    debounce_bit #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk       (clk),
      .reset     (reset),
      .i_pin     (pins_in[gi]),
      .o_stb     (w_stb[gi]),
      .o_stb_next(w_stb_next[gi])
    );
  end

  assign w_sel     = (addr[31:4] == BASE[31:4]);
  assign w_off     = gpio_off_e'(addr[3:2]);
  assign w_wr      = w_sel && mem_write;
  assign w_rise_ev = w_stb_next & ~w_stb;
  // Byte lane bits and data bits above WIDTH carry no meaning here
  assign w_unused  = ^{addr[1:0], write_data};

  // Next register values: set beats clear on RISE, event beats clear on COUNT
  always_comb begin
    w_clr        = '0;
    w_mask_next  = r_mask;
    w_count_next = r_count;
    if (w_wr && (w_off == GPIO_RISE))  w_clr = write_data[WIDTH-1:0];
    if (w_wr && (w_off == GPIO_MASK))  w_mask_next = write_data[WIDTH-1:0];
    if (w_wr && (w_off == GPIO_COUNT)) w_count_next = '0;
    w_count_next = w_count_next + COUNT_W'(|w_rise_ev);
    w_rise_next  = (r_rise & ~w_clr) | w_rise_ev;
  end

  // Register file and interrupt line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rise  <= '0;
      r_mask  <= '0;
      r_count <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_rise  <= w_rise_next;
      r_mask  <= w_mask_next;
      r_count <= w_count_next;
      r_irq   <= |(w_rise_next & w_mask_next);
    end
  end

  // Zero-wait-state read mux, silent when the window is not addressed
  always_comb begin
    read_data = '0;
    if (w_sel) begin
      case (w_off)
        GPIO_STATE: read_data = 32'(w_stb);
        GPIO_RISE:  read_data = 32'(r_rise);
        GPIO_COUNT: read_data = 32'(r_count);
        GPIO_MASK:  read_data = 32'(r_mask);
        default:    read_data = '0;
      endcase
    end
  end

  assign irq = r_irq;

endmodule

// File: tb/tb_gpio_input_port.sv
// Bench for gpio_input_port. A reference model (pin sample history window,
// plain register arithmetic) predicts every register; reads push the
// predicted value into a queue and a monitor compares the bus. A second,
// narrow instance with a short debounce runs the event counter through wrap.
module tb_gpio_input_port;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic [7:0]  pins = '0;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic        mem_write = 1'b0, irq;

  logic        rst2 = 1'b0;
  logic [3:0]  pins2 = '0;
  logic        mw2 = 1'b0;
  logic [31:0] rdata2;
  logic        irq2;
  logic        done2 = 1'b0;

  gpio_input_port #(.WIDTH(8), .DB_CYCLES(16), .BASE(BASE)) dut (
    .clk(clk), .reset(reset), .pins_in(pins), .addr(addr), .mem_write(mem_write),
    .write_data(wdata), .read_data(rdata), .irq(irq));

  gpio_input_port #(.WIDTH(4), .DB_CYCLES(2), .BASE(BASE)) dut2 (
    .clk(clk), .reset(rst2), .pins_in(pins2), .addr(32'hFFFF_FF08), .mem_write(mw2),
    .write_data(32'h0), .read_data(rdata2), .irq(irq2));

  typedef struct packed {
    logic [17:0][31:0] h;    // h[0] = pins at last edge, h[1] = one edge earlier, ...
    logic [31:0]       stb, rise, mask;
    logic [15:0]       cnt;
    logic              irq;
  } mdl_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic        irq;
  } exp_t;

  mdl_t m = '0, m2 = '0;
  exp_t sbq[$];
  exp_t e;
  logic rd_vld = 1'b0;
  int   passed = 0, total = 0;

  // A level is accepted once the synchronised pin (two edges late) has
  // disagreed with the accepted level on each of the last db edges.
  function automatic mdl_t mstep(input mdl_t mi, input int db, input int w,
                                 input logic [31:0] p, input logic [31:0] a,
                                 input logic we, input logic [31:0] wd);
    mdl_t        mo;
    logic [31:0] wm, nstb, ev, clr;
    logic        wr, flip;
    mo   = mi;
    wm   = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    nstb = mi.stb;
    for (int i = 0; i < w; i++) begin
      flip = 1'b1;
      for (int j = 1; j <= db; j++) if (mi.h[j][i] == mi.stb[i]) flip = 1'b0;
      if (flip) nstb[i] = ~mi.stb[i];
    end
    ev  = nstb & ~mi.stb;
    wr  = (a[31:4] == BASE[31:4]) && we;
    clr = (wr && a[3:2] == 2'd1) ? (wd & wm) : 32'h0;
    mo.rise = (mi.rise & ~clr) | ev;
    mo.cnt  = ((wr && a[3:2] == 2'd2) ? 16'h0 : mi.cnt) + ((ev != 0) ? 16'h1 : 16'h0);
    if (wr && a[3:2] == 2'd3) mo.mask = wd & wm;
    mo.irq = |(mo.rise & mo.mask);
    mo.stb = nstb;
    for (int j = 17; j > 0; j--) mo.h[j] = mi.h[j-1];
    mo.h[0] = p & wm;
    return mo;
  endfunction

  function automatic logic [31:0] rdexp(input mdl_t mm, input logic [31:0] a);
    if (a[31:4] != BASE[31:4]) return 32'h0;
    case (a[3:2])
      2'd0:    return mm.stb;
      2'd1:    return mm.rise;
      2'd2:    return {16'h0, mm.cnt};
      default: return mm.mask;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Reference models advance on the same edges as the DUTs
  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) m = '0;
    else m = mstep(m, 16, 8, {24'h0, pins}, addr, mem_write, wdata);
  end

  initial forever begin
    @(posedge clk or negedge rst2);
    if (!rst2) m2 = '0;
    else m2 = mstep(m2, 2, 4, {28'h0, pins2}, 32'hFFFF_FF08, mw2, 32'h0);
  end

  // Monitor: every issued read is compared once, away from the clock edge
  initial forever begin
    @(negedge clk);
    #2;
    if (rd_vld) begin
      if (sbq.size() == 0) begin
        total++;
        $display("FAIL sb_underflow: read with no expected entry at %0t", $time);
      end else begin
        e = sbq.pop_front();
        check($sformatf("rdata@%h", e.a), rdata, e.d);
        check($sformatf("irq@%h", e.a), {31'h0, irq}, {31'h0, e.irq});
      end
    end
  end

  task automatic cyc(input logic [31:0] a, input logic w, input logic [31:0] d, input logic r);
    addr = a; mem_write = w; wdata = d; rd_vld = r;
    if (r) sbq.push_back('{a: a, d: rdexp(m, a), irq: m.irq});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic rd(input logic [3:0] off);
    cyc(BASE | {28'h0, off}, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d);
    cyc(BASE | {28'h0, off}, 1'b1, d, 1'b0);
  endtask

  // Narrow instance: each of 4 pins toggles 2 high / 2 low, staggered, so a
  // rising edge lands on nearly every clock and COUNT sweeps through wrap.
  initial begin
    wait (rst2);
    for (int c = 0; c < 66000; c++) begin
      @(negedge clk);
      #2;
      if (c > 0 && (m2.cnt <= 16'd3 || m2.cnt >= 16'hFFFD))
        check($sformatf("count2 c=%0d", c), rdata2, {16'h0, m2.cnt});
      for (int i = 0; i < 4; i++) pins2[i] = (((c + 4 - i) % 4) < 2);
      mw2 = (c == 100);
    end
    done2 = 1'b1;
  end

  initial begin
    logic [31:0] ra;
    int          op;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    rst2  = 1'b1;

    // Quiet after reset, plus an unmapped read
    idle(40);
    rd(4'h0); rd(4'h4); rd(4'h8); rd(4'hC);
    cyc(32'h0000_0100, 1'b0, 32'h0, 1'b1);

    // Bit 3 rises: sweep STATE across the acceptance edge
    pins = 8'h08;
    repeat (22) rd(4'h0);
    rd(4'h4); rd(4'h8);

    // Bit 0: 15-clock glitch rejected, 16-clock pulse accepted
    pins = 8'h09; repeat (15) rd(4'h0);
    pins = 8'h08; idle(20);
    pins = 8'h09; repeat (16) rd(4'h0);
    pins = 8'h08; repeat (4) rd(4'h0);
    rd(4'h4);
    idle(20); rd(4'h0);

    // Mask bit 3 and watch irq follow a new rise
    wr(4'hC, 32'h08); wr(4'h4, 32'hFF); rd(4'h4); rd(4'hC);
    pins = 8'h00; idle(20);
    pins = 8'h08; repeat (20) rd(4'h4);

    // Clear on the same edge as a new rise: set wins
    pins = 8'h00; idle(20);
    pins = 8'h08; idle(17);
    wr(4'h4, 32'h08); rd(4'h4); rd(4'h4);
    // Lone clear drops RISE and then irq
    wr(4'h4, 32'h08); rd(4'h4); rd(4'h4);

    // COUNT clear with and without a concurrent event
    wr(4'h8, 32'h0); rd(4'h8);
    pins = 8'h00; idle(20);
    pins = 8'h08; idle(17);
    wr(4'h8, 32'h0); rd(4'h8);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) pins = 8'($urandom);
      op = int'($urandom_range(0, 3));
      case (op)
        0: idle(1);
        1: rd({2'($urandom), 2'b00} | 4'($urandom_range(0, 3)));
        2: wr({2'($urandom), 2'b00}, $urandom);
        default: begin
          ra = $urandom & 32'h7FFF_FFFF;
          cyc(ra, 1'($urandom), $urandom, 1'b1);
        end
      endcase
    end

    // Asynchronous reset in the middle of a bit-5 debounce
    wr(4'hC, 32'hFF);
    pins = 8'h00; idle(25);
    pins = 8'h20; idle(12);
    rd_vld = 1'b0;
    #3 reset = 1'b0;
    @(negedge clk);
    rd(4'h0); rd(4'h4); rd(4'h8); rd(4'hC);
    rd_vld = 1'b0;
    #3 reset = 1'b1;
    @(negedge clk);
    repeat (22) rd(4'h0);
    rd(4'h4); rd(4'h8);
    idle(2);

    for (int n = 0; n < 80000 && !done2; n++) @(negedge clk);
    if (!done2) begin
      total++;
      $display("FAIL inst2_timeout: done=%0d required 1", done2);
    end
    if (sbq.size() != 0) begin
      total++;
      $display("FAIL sb_leftover: %0d entries, required 0", sbq.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
